// File: rtl/md_unit_e_pkg.sv
// md_defs: op encodings and default latencies
// for the execute-stage multiply/divide unit.
package md_defs;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul(
    input logic [2:0] op
  );
    return (op == MD_MULT) ||
           (op == MD_MULTU);
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return (op == MD_DIV) ||
           (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_e_calc.sv
// md_calc: combinational 64-bit HI/LO result
// for mult/div ops; res_we drops on divide by zero.
module md_calc
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_we
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] q;
  logic [31:0] r;
  logic        sdiv;
  logic        dz;

  assign prod_s = $signed({{32{a[31]}}, a}) *
                  $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // magnitude divide; signs re-applied below so
  // 0x80000000 / -1 wraps cleanly to 0x80000000
  always_comb begin
    sdiv = (op == MD_DIV);
    dz   = (b == 32'd0);
    ua   = (sdiv && a[31]) ? -a : a;
    ub   = (sdiv && b[31]) ? -b : b;
    if (dz) ub = 32'd1;
    q = ua / ub;
    r = ua % ub;
  end

  // select the result for the decoded op
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b0;
    unique case (1'b1)
      (op == MD_MULT): begin
        {res_hi, res_lo} = prod_s;
        res_we = 1'b1;
      end
      (op == MD_MULTU): begin
        {res_hi, res_lo} = prod_u;
        res_we = 1'b1;
      end
      (op == MD_DIV): begin
        res_lo = (a[31] ^ b[31]) ? -q : q;
        res_hi = a[31] ? -r : r;
        res_we = ~dz;
      end
      (op == MD_DIVU): begin
        res_lo = q;
        res_hi = r;
        res_we = ~dz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_e.sv
// md_unit_e: E-stage multiply/divide unit with
// HI/LO registers and a busy-counter latency model.
module md_unit_e
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  md_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic          state;
  logic [CW-1:0] cnt;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_we;
  logic [31:0]   c_hi;
  logic [31:0]   c_lo;
  logic          c_we;

  md_calc u_calc (
    .op     (md_op),
    .a      (a),
    .b      (b),
    .res_hi (c_hi),
    .res_lo (c_lo),
    .res_we (c_we)
  );

  assign busy = (state == ST_RUN);

  // capture on start, count down, commit at cnt==1
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_we <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        if (is_mul(md_op) || is_div(md_op)) begin
          res_hi <= c_hi;
          res_lo <= c_lo;
          res_we <= c_we;
          cnt    <= is_mul(md_op) ?
                    CW'(MULT_CYCLES) :
                    CW'(DIV_CYCLES);
          state  <= ST_RUN;
        end else if (md_op == MD_MTHI) begin
          hi <= a;
        end else if (md_op == MD_MTLO) begin
          lo <= a;
        end
      end
    end else begin
      if (cnt == CW'(1)) begin
        if (res_we) begin
          hi <= res_hi;
          lo <= res_lo;
        end
        res_we <= 1'b0;
        cnt    <= '0;
        state  <= ST_IDLE;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/md_unit_e.md
Name: md_unit_E

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the forwarded E-stage operands, i.e. the outputs of the E-stage operand muxes, plus a decoded md_op.
- Holds the architectural HI/LO registers and models multi-cycle MULT/DIV latency through a busy counter.
- The hazard unit stalls D when an md instruction (or MFHI/MFLO) is in D while start or busy is high.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for MULT/MULTU
- DIV_CYCLES, 10, cycles busy is held for DIV/DIVU

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high; clears all state
- a  input  32  rs operand (after forwarding)
- b  input  32  rt operand (after forwarding)
- md_op  input  3  operation code, encodings in package
- start  input  1  one-cycle pulse while the md instruction is in E
- busy  output  1  operation in progress
- hi  output  32  architectural HI (read by MFHI)
- lo  output  32  architectural LO (read by MFLO)

Behaviour:
- All updates occur on posedge clk.
- Reset (synchronous, active-high) forces: hi=0, lo=0, busy=0, cnt=0, pending result cleared.
  - Reset mid-operation abandons the operation; HI/LO stay 0.
- md_op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6; codes 7+ are treated as NONE.
- State machine, two states:
  - IDLE: busy=0.
  - RUN: busy=1, cnt counting down.
- IDLE, start=1, md_op MULT/MULTU/DIV/DIVU:
  - Capture the result into internal res_hi/res_lo from a, b in that cycle.
  - Load cnt=MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy rises the cycle after start.
- RUN: cnt decrements each cycle. In the cycle cnt==1:
  - hi<=res_hi, lo<=res_lo.
  - Go to IDLE; busy falls the next cycle.
  - Net result: busy is high for exactly N cycles, and new HI/LO are visible the same cycle busy deasserts.
- start with MTHI/MTLO in IDLE: hi<=a or lo<=a at that edge; no busy.
- start with NONE: no effect.
- start while in RUN: ignored (the hazard unit guarantees this cannot happen; the block stays safe regardless).
- MULT: {hi,lo} = signed a × signed b, 64-bit.
- MULTU: unsigned 64-bit product.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b==0, DIV or DIVU):
  - busy is still held DIV_CYCLES.
  - HI and LO are left unchanged at completion.
- Outputs hi/lo are plain register outputs with no bypass. MFHI/MFLO is held in D by the stall until busy==0 and start==0.

Decomposition:
- Package md_defs holds:
  - md_op localparams (MD_NONE..MD_MTLO).
  - Default cycle counts MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10.
- Optional sub-module md_calc: combinational 64-bit mult/div result for a given op, containing the signed/unsigned and divide-by-zero logic.
- Counter and FSM stay in md_unit_E.

Test Plan:
- MULT signed: start, a=0xFFFFFFFE (-2), b=3 -> busy high cycles 1..5 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: a=0xFFFFFFFF, b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV signed: a=-7 (0xFFFFFFF9), b=2 -> busy exactly 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with b=0, after MTHI a=0x1234 and MTLO a=0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- Reset in RUN: MULT 3×4, assert reset at busy cycle 3 -> next cycle busy=0, hi=lo=0; never 12.
- Second start during RUN: DIVU 100/7, then start MULT 2×2 at busy cycle 4 -> ignored; final lo=14, hi=2, busy total 10.
